// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port between I-cache and D-cache.
// Holds the grant until completion or abort; keeps saturating completion counters.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req_valid,
  input  logic              i_req_rw,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [LINE_W-1:0] i_req_data,
  output logic              i_res_ready,
  output logic [LINE_W-1:0] i_res_data,
  input  logic              d_req_valid,
  input  logic              d_req_rw,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [LINE_W-1:0] d_req_data,
  output logic              d_res_ready,
  output logic [LINE_W-1:0] d_res_data,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  i_txn_count,
  output logic [CNT_W-1:0]  d_txn_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam logic LG_I = 1'b0;
  localparam logic LG_D = 1'b1;

  state_t state;
  logic   last_grant;
  logic   gnt_i;
  logic   gnt_d;

  assign gnt_i = (state == GRANT_I);
  assign gnt_d = (state == GRANT_D);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= LG_I;
      i_txn_count <= '0;
      d_txn_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_req_valid && d_req_valid)
            state <= (last_grant == LG_D) ? GRANT_I : GRANT_D;
          else if (i_req_valid)
            state <= GRANT_I;
          else if (d_req_valid)
            state <= GRANT_D;
        end
        GRANT_I: begin
          if (mem_ready) begin
            state      <= IDLE;
            last_grant <= LG_I;
            if (i_txn_count != '1)
              i_txn_count <= i_txn_count + 1'b1;
          end else if (!i_req_valid) begin
            state <= IDLE;
          end
        end
        GRANT_D: begin
          if (mem_ready) begin
            state      <= IDLE;
            last_grant <= LG_D;
            if (d_txn_count != '1)
              d_txn_count <= d_txn_count + 1'b1;
          end else if (!d_req_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory side and responses follow the registered grant with no added latency.
  always_comb begin
    mem_valid   = 1'b0;
    mem_rw      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    i_res_ready = 1'b0;
    i_res_data  = '0;
    d_res_ready = 1'b0;
    d_res_data  = '0;
    unique case (1'b1)
      gnt_i: begin
        mem_valid   = i_req_valid;
        mem_rw      = i_req_rw;
        mem_addr    = i_req_addr;
        mem_wdata   = i_req_data;
        i_res_ready = mem_ready;
        i_res_data  = mem_rdata;
      end
      gnt_d: begin
        mem_valid   = d_req_valid;
        mem_rw      = d_req_rw;
        mem_addr    = d_req_addr;
        mem_wdata   = d_req_data;
        d_res_ready = mem_ready;
        d_res_data  = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant order, routing, abort, reset.
// A 2-bit-counter twin shares all inputs to exercise saturation.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;
  localparam int CW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_req_valid, i_req_rw;
  logic [AW-1:0] i_req_addr;
  logic [LW-1:0] i_req_data;
  logic          i_res_ready;
  logic [LW-1:0] i_res_data;
  logic          d_req_valid, d_req_rw;
  logic [AW-1:0] d_req_addr;
  logic [LW-1:0] d_req_data;
  logic          d_res_ready;
  logic [LW-1:0] d_res_data;
  logic          mem_valid, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ready;
  logic [LW-1:0] mem_rdata;
  logic [CW-1:0] i_txn_count, d_txn_count;

  logic          s_i_res_ready, s_d_res_ready;
  logic [LW-1:0] s_i_res_data, s_d_res_data;
  logic          s_mem_valid, s_mem_rw;
  logic [AW-1:0] s_mem_addr;
  logic [LW-1:0] s_mem_wdata;
  logic [1:0]    s_i_cnt, s_d_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [LW-1:0] RD =
    128'hDEADBEEF_01234567_89ABCDEF_0F1E2D3C;
  localparam logic [LW-1:0] A5 = {4{32'hA5A5A5A5}};

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_rw(i_req_rw),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .i_res_ready(i_res_ready), .i_res_data(i_res_data),
    .d_req_valid(d_req_valid), .d_req_rw(d_req_rw),
    .d_req_addr(d_req_addr), .d_req_data(d_req_data),
    .d_res_ready(d_res_ready), .d_res_data(d_res_data),
    .mem_valid(mem_valid), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .i_txn_count(i_txn_count), .d_txn_count(d_txn_count)
  );

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(2)) sat (
    .clock(clock), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_rw(i_req_rw),
    .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .i_res_ready(s_i_res_ready), .i_res_data(s_i_res_data),
    .d_req_valid(d_req_valid), .d_req_rw(d_req_rw),
    .d_req_addr(d_req_addr), .d_req_data(d_req_data),
    .d_res_ready(s_d_res_ready), .d_res_data(s_d_res_data),
    .mem_valid(s_mem_valid), .mem_rw(s_mem_rw),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .i_txn_count(s_i_cnt), .d_txn_count(s_d_cnt)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [LW-1:0] obs,
                     input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b0;
    i_req_valid = 1'b0; i_req_rw = 1'b0;
    i_req_addr  = '0;   i_req_data = '0;
    d_req_valid = 1'b0; d_req_rw = 1'b0;
    d_req_addr  = '0;   d_req_data = '0;
    mem_ready   = 1'b0; mem_rdata = '0;
    #1;
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_icnt", i_txn_count, 0);
    chk("rst_dcnt", d_txn_count, 0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // single D fill
    d_req_valid = 1'b1; d_req_rw = 1'b0; d_req_addr = 32'h40;
    #1;
    chk("s1_idle_valid", mem_valid, 0);
    tick();
    chk("s1_grant_valid", mem_valid, 1);
    chk("s1_grant_addr", mem_addr, 32'h40);
    chk("s1_grant_rw", mem_rw, 0);
    tick();
    tick();
    mem_ready = 1'b1; mem_rdata = RD;
    #1;
    chk("s1_dres_ready", d_res_ready, 1);
    chk("s1_dres_data", d_res_data, RD);
    chk("s1_ires_ready", i_res_ready, 0);
    chk("s1_ires_data", i_res_data, 0);
    chk("s1_dcnt_before", d_txn_count, 0);
    tick();
    mem_ready = 1'b0; d_req_valid = 1'b0;
    #1;
    chk("s1_idle_after", mem_valid, 0);
    chk("s1_dcnt_after", d_txn_count, 1);
    chk("s1_sat_dcnt", s_d_cnt, 1);

    // reset, then continuous tie: D, I, D, I
    reset = 1'b0;
    #1;
    chk("s2_rst_dcnt", d_txn_count, 0);
    tick();
    reset = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    d_req_valid = 1'b1; d_req_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      logic exp_d;
      exp_d = (k % 2 == 0);
      tick();
      chk("s2_grant_addr", mem_addr, exp_d ? 32'h200 : 32'h100);
      mem_ready = 1'b1; mem_rdata = LW'(k);
      #1;
      chk("s2_dres", d_res_ready, exp_d);
      chk("s2_ires", i_res_ready, !exp_d);
      tick();
      mem_ready = 1'b0;
      #1;
      chk("s2_bubble", mem_valid, 0);
    end
    chk("s2_icnt", i_txn_count, 2);
    chk("s2_dcnt", d_txn_count, 2);
    chk("s2_sat_icnt", s_i_cnt, 2);
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    tick();

    // D write-back with I waiting, then D fill
    d_req_valid = 1'b1; d_req_rw = 1'b1;
    d_req_addr = 32'h1230; d_req_data = A5;
    tick();
    i_req_valid = 1'b1; i_req_rw = 1'b0; i_req_addr = 32'h300;
    #1;
    chk("s3_wb_rw", mem_rw, 1);
    chk("s3_wb_addr", mem_addr, 32'h1230);
    chk("s3_wb_wdata", mem_wdata, A5);
    mem_ready = 1'b1;
    #1;
    tick();
    mem_ready = 1'b0; d_req_rw = 1'b0; d_req_addr = 32'h30;
    #1;
    chk("s3_bubble", mem_valid, 0);
    chk("s3_dcnt_wb", d_txn_count, 3);
    chk("s3_sat_dcnt_wb", s_d_cnt, 3);
    tick();
    chk("s3_i_between", mem_addr, 32'h300);
    chk("s3_i_rw", mem_rw, 0);
    mem_ready = 1'b1;
    #1;
    chk("s3_ires", i_res_ready, 1);
    tick();
    mem_ready = 1'b0; i_req_valid = 1'b0;
    tick();
    chk("s3_fill_addr", mem_addr, 32'h30);
    chk("s3_fill_rw", mem_rw, 0);
    mem_ready = 1'b1;
    #1;
    tick();
    mem_ready = 1'b0; d_req_valid = 1'b0;
    #1;
    chk("s3_dcnt", d_txn_count, 4);
    chk("s3_sat_dcnt_hold", s_d_cnt, 3);
    chk("s3_icnt", i_txn_count, 3);
    chk("s3_sat_icnt", s_i_cnt, 3);

    // abort, spurious ready in IDLE
    i_req_valid = 1'b1; i_req_addr = 32'h400;
    tick();
    chk("s4_grant", mem_valid, 1);
    tick();
    i_req_valid = 1'b0;
    #1;
    chk("s4_abort_valid", mem_valid, 0);
    tick();
    chk("s4_abort_icnt", i_txn_count, 3);
    mem_ready = 1'b1; mem_rdata = RD;
    #1;
    chk("s4_spur_ires", i_res_ready, 0);
    chk("s4_spur_dres", d_res_ready, 0);
    chk("s4_spur_idata", i_res_data, 0);
    chk("s4_spur_ddata", d_res_data, 0);
    tick();
    mem_ready = 1'b0;
    #1;
    chk("s4_spur_valid", mem_valid, 0);
    chk("s4_spur_icnt", i_txn_count, 3);
    chk("s4_spur_dcnt", d_txn_count, 4);

    // abort must not move last_grant (still D): tie goes to I
    i_req_valid = 1'b1; i_req_addr = 32'h500;
    d_req_valid = 1'b1; d_req_addr = 32'h600;
    tick();
    chk("s4_tie_after_abort", mem_addr, 32'h500);
    mem_ready = 1'b1;
    #1;
    tick();
    mem_ready = 1'b0; i_req_valid = 1'b0;
    #1;
    chk("s4_icnt", i_txn_count, 4);
    chk("s4_sat_icnt_hold", s_i_cnt, 3);

    // reset in the middle of a D grant
    tick();
    chk("s5_grant_d", mem_valid, 1);
    chk("s5_grant_addr", mem_addr, 32'h600);
    mem_ready = 1'b1;
    #1;
    chk("s5_dres_pre", d_res_ready, 1);
    reset = 1'b0;
    #1;
    chk("s5_rst_valid", mem_valid, 0);
    chk("s5_rst_dres", d_res_ready, 0);
    chk("s5_rst_ddata", d_res_data, 0);
    chk("s5_rst_addr", mem_addr, 0);
    chk("s5_rst_icnt", i_txn_count, 0);
    chk("s5_rst_dcnt", d_txn_count, 0);
    chk("s5_rst_sat_dcnt", s_d_cnt, 0);
    tick();
    mem_ready = 1'b0; i_req_valid = 1'b1;
    reset = 1'b1;
    #1;
    chk("s5_idle_valid", mem_valid, 0);
    tick();
    chk("s5_first_tie_d", mem_addr, 32'h600);
    chk("s5_first_tie_dv", mem_valid, 1);
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
